spectrum_frame_scheduler: RTL



---
 rtl/vis_pkg.sv | 26 ++
 rtl/bin_scaler.sv | 29 ++
 rtl/spectrum_frame_scheduler.sv | 130 +++++++++++++
 3 files changed

// File: rtl/vis_pkg.sv
// Shared types and constants for the spectrum bar display path.
// Heights are unsigned line counts; bin indices address both banks and the peak store.
package vis_pkg;

  localparam int NUM_BINS   = 16;
  localparam int DATA_W     = 24;
  localparam int FULL_SCALE = 32767;
  localparam int HEIGHT_MAX = 480;
  localparam int H_W        = 9;
  localparam int PEAK_DECAY = 2;
  localparam int IDX_W      = $clog2(NUM_BINS);

  typedef enum logic [1:0] {
    LOAD,
    PEND,
    PEAK
  } sched_state_t;

  typedef logic [H_W-1:0] height_t;

  // Peak minus the decay step, floored at zero.
  function automatic height_t decay_sat(input height_t h);
    return (h > height_t'(PEAK_DECAY)) ? h - height_t'(PEAK_DECAY) : '0;
  endfunction

endpackage

// File: rtl/bin_scaler.sv
// Clamps a signed bin to [0, FULL_SCALE] and scales it to a bar height in 0..479.
// x*480 is formed as (x<<9)-(x<<5); the 25-bit intermediate cannot overflow.
module bin_scaler
  import vis_pkg::*;
(
  input  logic [DATA_W-1:0] i_bin,
  output logic [H_W-1:0]    o_height
);

  localparam logic [DATA_W-1:0] FULL_SCALE_D = DATA_W'(FULL_SCALE);

  logic [14:0] w_clamped;
  logic [24:0] w_scaled;

  always_comb begin
    w_clamped = '0;
    if (i_bin[DATA_W-1]) begin
      w_clamped = '0;
    end else if (i_bin > FULL_SCALE_D) begin
      w_clamped = 15'(FULL_SCALE);
    end else begin
      w_clamped = i_bin[14:0];
    end
  end

  assign w_scaled = ({10'd0, w_clamped} << 9) - ({10'd0, w_clamped} << 5);
  assign o_height = H_W'(w_scaled >> 15);

endmodule

// File: rtl/spectrum_frame_scheduler.sv
// Double-buffered bar-height store: loads a 16-bin frame into the shadow bank,
// swaps at vblank start, then refreshes the decaying peak-hold one bin per cycle.
module spectrum_frame_scheduler
  import vis_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  input  logic              vblank_start,
  input  logic [IDX_W-1:0]  rd_col,
  output logic [H_W-1:0]    rd_height,
  output logic [H_W-1:0]    rd_peak,
  output logic              frame_swapped,
  output logic              frame_err
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BINS - 1);

  sched_state_t     r_state;
  logic             r_bank_sel;
  logic [IDX_W-1:0] r_idx;
  logic             r_in_ready;
  logic             r_swapped;
  logic             r_err;
  height_t          r_rd_height;
  height_t          r_rd_peak;
  height_t          r_bank0 [NUM_BINS];
  height_t          r_bank1 [NUM_BINS];
  height_t          r_peak  [NUM_BINS];

  logic    w_accept;
  logic    w_at_last;
  height_t w_height;
  height_t w_active_at_idx;
  height_t w_decayed;
  height_t w_peak_next;

  bin_scaler u_scaler (
    .i_bin    (in_data),
    .o_height (w_height)
  );

  assign w_accept        = in_valid && r_in_ready && (r_state == LOAD);
  assign w_at_last       = (r_idx == LAST_IDX);
  assign w_active_at_idx = r_bank_sel ? r_bank1[r_idx] : r_bank0[r_idx];
  assign w_decayed       = decay_sat(r_peak[r_idx]);
  assign w_peak_next     = (w_active_at_idx > w_decayed) ? w_active_at_idx : w_decayed;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= LOAD;
      r_bank_sel  <= 1'b0;
      r_idx       <= '0;
      r_in_ready  <= 1'b0;
      r_swapped   <= 1'b0;
      r_err       <= 1'b0;
      r_rd_height <= '0;
      r_rd_peak   <= '0;
      for (int i = 0; i < NUM_BINS; i++) begin
        r_bank0[i] <= '0;
        r_bank1[i] <= '0;
        r_peak[i]  <= '0;
      end
    end else begin
      r_swapped   <= 1'b0;
      r_err       <= 1'b0;
      // Read uses the pre-update bank select, so a swap-cycle read sees the old bank.
      r_rd_height <= r_bank_sel ? r_bank1[rd_col] : r_bank0[rd_col];
      r_rd_peak   <= r_peak[rd_col];

      unique case (r_state)
        LOAD: begin
          r_in_ready <= 1'b1;
          if (w_accept) begin
            if (r_bank_sel) r_bank0[r_idx] <= w_height;
            else            r_bank1[r_idx] <= w_height;
            if (w_at_last && in_last) begin
              r_state    <= PEND;
              r_idx      <= '0;
              r_in_ready <= 1'b0;
            end else if (w_at_last || in_last) begin
              r_err <= 1'b1;
              r_idx <= '0;
            end else begin
              r_idx <= r_idx + 1'b1;
            end
          end
        end

        PEND: begin
          r_in_ready <= 1'b0;
          if (vblank_start) begin
            r_bank_sel <= ~r_bank_sel;
            r_swapped  <= 1'b1;
            r_state    <= PEAK;
          end
        end

        PEAK: begin
          // r_idx doubles as the peak sweep pointer; it is 0 on entry.
          r_peak[r_idx] <= w_peak_next;
          if (w_at_last) begin
            r_state    <= LOAD;
            r_idx      <= '0;
            r_in_ready <= 1'b1;
          end else begin
            r_idx      <= r_idx + 1'b1;
            r_in_ready <= 1'b0;
          end
        end

        default: begin
          r_state    <= LOAD;
          r_idx      <= '0;
          r_in_ready <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready      = r_in_ready;
  assign rd_height     = r_rd_height;
  assign rd_peak       = r_rd_peak;
  assign frame_swapped = r_swapped;
  assign frame_err     = r_err;

endmodule
